result_collector: RTL and testbench

Output-side counterpart to the systolic-array scheduler: captures the skewed partial-sum stream leaving the bottom of the array, deskews it into complete rows, and hands rows downstream over a valid/ready interface. It sits between the array's last PE row and the result writer. It tracks the row count for one matrix and raises `done` once the final row has been drained, closing the schedule the scheduler opened.

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/row_fifo.sv | 64 ++++++
 rtl/result_collector.sv | 207 ++++++++++++++++++++
 tb/tb_result_collector.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: types, defaults and helpers shared by the systolic-array
// scheduler and the result collector.
package systolic_pkg;

    // Collector life cycle for one matrix.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } collector_state_e;

    // Default width of one partial sum.
    localparam int DEFAULT_DATA_SIZE = 32;

    // Bit offset of column `col` inside a packed row; column 0 sits in the LSBs.
    function automatic int col_lsb(input int col, input int data_size);
        return col * data_size;
    endfunction

endpackage

// File: rtl/row_fifo.sv
// row_fifo: small synchronous FIFO holding deskewed rows. A push into a full
// FIFO is accepted when a pop happens in the same cycle. The head entry is
// presented combinationally and reads as zero while the FIFO is empty.
module row_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Row storage; left unreset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

    assign head_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/result_collector.sv
// result_collector: deskews the skewed column stream leaving the bottom of the
// systolic array into whole rows, buffers them in row_fifo and hands them
// downstream over valid/ready, raising done once a full matrix has drained.
// Build macro RESULT_COLLECTOR_ERR_CHECK_EN adds the column-alignment check
// that drives err; without it err is tied low.
module result_collector
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = DEFAULT_DATA_SIZE,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             general_enable,
    input  logic                             start,
    input  logic [MATRIX_SIZE-1:0]           col_valid,
    input  logic [MATRIX_SIZE*DATA_SIZE-1:0] col_data,
    output logic                             row_valid,
    output logic [MATRIX_SIZE*DATA_SIZE-1:0] row_data,
    output logic [$clog2(MATRIX_SIZE):0]     row_index,
    input  logic                             row_ready,
    output logic                             busy,
    output logic                             done,
    output logic                             overflow,
    output logic                             err
);

    localparam int N  = MATRIX_SIZE;
    localparam int IW = $clog2(N) + 1;
    localparam int RW = N * DATA_SIZE;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IW-1:0] ROWS = IW'(N);

    collector_state_e state_q, state_d;
    logic [IW-1:0]    push_cnt_q, push_cnt_d;
    logic [IW-1:0]    pop_cnt_q, pop_cnt_d;
    logic             overflow_q, overflow_d;
    logic             flush;
    logic [N-1:0]     aln_valid_c, aln_valid_q;
    logic [RW-1:0]    aln_data_c, aln_data_q;
    logic             row_arrive;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [RW+IW-1:0] fifo_head;

    // A start is only honoured between matrices; it also flushes the deskew path.
    assign flush = start && (state_q == IDLE || state_q == DONE);

    // Column j is delayed N-1-j cycles so that all columns line up with column N-1.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_col
            localparam int DEPTH = N - 1 - gi;
            if (DEPTH == 0) begin : g_pass
                assign aln_valid_c[gi] = col_valid[gi];
                assign aln_data_c[col_lsb(gi, DATA_SIZE) +: DATA_SIZE] =
                    col_data[col_lsb(gi, DATA_SIZE) +: DATA_SIZE];
            end else begin : g_dly
                logic [DEPTH-1:0]     v_q;
                logic [DATA_SIZE-1:0] d_q [DEPTH];
                // Skew-compensation shift chain, frozen while general_enable is low.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        v_q <= '0;
                        for (int k = 0; k < DEPTH; k++) d_q[k] <= '0;
                    end else if (flush) begin
                        v_q <= '0;
                        for (int k = 0; k < DEPTH; k++) d_q[k] <= '0;
                    end else if (general_enable) begin
                        v_q[0] <= col_valid[gi];
                        d_q[0] <= col_data[col_lsb(gi, DATA_SIZE) +: DATA_SIZE];
                        for (int k = 1; k < DEPTH; k++) begin
                            v_q[k] <= v_q[k-1];
                            d_q[k] <= d_q[k-1];
                        end
                    end
                end
                assign aln_valid_c[gi] = v_q[DEPTH-1];
                assign aln_data_c[col_lsb(gi, DATA_SIZE) +: DATA_SIZE] = d_q[DEPTH-1];
            end
        end
    endgenerate

    // Aligned-row stage: a complete row is written into the FIFO one cycle after its last column.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aln_valid_q <= '0;
            aln_data_q  <= '0;
        end else if (flush) begin
            aln_valid_q <= '0;
            aln_data_q  <= '0;
        end else if (general_enable) begin
            aln_valid_q <= aln_valid_c;
            aln_data_q  <= aln_data_c;
        end
    end

    // Rows outside COLLECT are discarded; the row number travels with the data.
    assign row_arrive = general_enable && aln_valid_q[N-1] && (state_q == COLLECT);
    assign pop        = !fifo_empty && row_ready;

    row_fifo #(
        .WIDTH(RW + IW),
        .DEPTH(FIFO_DEPTH)
    ) u_row_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (row_arrive),
        .push_data_i({push_cnt_q, aln_data_q}),
        .pop_i      (row_ready),
        .head_data_o(fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    // Next state, saturating row counters and overflow flag.
    always_comb begin
        state_d    = state_q;
        push_cnt_d = push_cnt_q;
        pop_cnt_d  = pop_cnt_q;
        overflow_d = overflow_q;
        if (row_arrive && push_cnt_q != ROWS) begin
            push_cnt_d = push_cnt_q + IW'(1);
        end
        if (pop && pop_cnt_q != ROWS) begin
            pop_cnt_d = pop_cnt_q + IW'(1);
        end
        if (row_arrive && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = COLLECT;
                    push_cnt_d = '0;
                    pop_cnt_d  = '0;
                    overflow_d = 1'b0;
                end
            end
            COLLECT: begin
                if (push_cnt_d == ROWS) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop_cnt_d == ROWS && (fifo_empty || (fifo_count == CW'(1) && pop))) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            push_cnt_q <= push_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef RESULT_COLLECTOR_ERR_CHECK_EN
    logic err_q, err_d;

    // A row closed by column N-1 must have every column valid; the row is still kept.
    always_comb begin
        err_d = err_q;
        if (flush) begin
            err_d = 1'b0;
        end else if (row_arrive && !(&aln_valid_q)) begin
            err_d = 1'b1;
        end
    end

    // Sticky alignment error register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_aln_valid;
    assign unused_aln_valid = ^aln_valid_q[N-2:0];
    assign err = 1'b0;
`endif

    assign row_valid = !fifo_empty;
    assign row_data  = fifo_head[RW-1:0];
    assign row_index = fifo_head[RW +: IW];
    assign busy      = (state_q == COLLECT) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: directed bench for result_collector with a scoreboard
// per instance (A: N=2, depth 4; B: N=4, depth 2). Expected rows are queued as
// the last column is driven and checked when the DUT hands the row out.
module tb_result_collector;

`ifdef RESULT_COLLECTOR_ERR_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic general_enable;

    logic         a_start, a_row_ready, a_row_valid, a_busy, a_done, a_overflow, a_err;
    logic [1:0]   a_col_valid;
    logic [63:0]  a_col_data, a_row_data;
    logic [1:0]   a_row_index;

    logic         b_start, b_row_ready, b_row_valid, b_busy, b_done, b_overflow, b_err;
    logic [3:0]   b_col_valid;
    logic [127:0] b_col_data, b_row_data;
    logic [2:0]   b_row_index;

    int tests = 0;
    int fails = 0;

    logic [65:0]  a_q[$];
    logic [130:0] b_q[$];

    result_collector #(.MATRIX_SIZE(2), .DATA_SIZE(32), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .reset(reset), .general_enable(general_enable), .start(a_start),
        .col_valid(a_col_valid), .col_data(a_col_data), .row_valid(a_row_valid),
        .row_data(a_row_data), .row_index(a_row_index), .row_ready(a_row_ready),
        .busy(a_busy), .done(a_done), .overflow(a_overflow), .err(a_err)
    );

    result_collector #(.MATRIX_SIZE(4), .DATA_SIZE(32), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .reset(reset), .general_enable(general_enable), .start(b_start),
        .col_valid(b_col_valid), .col_data(b_col_data), .row_valid(b_row_valid),
        .row_data(b_row_data), .row_index(b_row_index), .row_ready(b_row_ready),
        .busy(b_busy), .done(b_done), .overflow(b_overflow), .err(b_err)
    );

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_a_reset(input string tag);
        check({tag, "_row_valid"}, 160'(a_row_valid), 160'(0));
        check({tag, "_row_data"},  160'(a_row_data),  160'(0));
        check({tag, "_row_index"}, 160'(a_row_index), 160'(0));
        check({tag, "_busy"},      160'(a_busy),      160'(0));
        check({tag, "_done"},      160'(a_done),      160'(0));
        check({tag, "_overflow"},  160'(a_overflow),  160'(0));
        check({tag, "_err"},       160'(a_err),       160'(0));
    endtask

    task automatic a_cycle(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1);
        a_col_valid = v;
        a_col_data  = {d1, d0};
        @(posedge clk); #1;
    endtask

    task automatic b_cycle(input logic [3:0] v, input logic [127:0] d);
        b_col_valid = v;
        b_col_data  = d;
        @(posedge clk); #1;
    endtask

    task automatic a_start_matrix();
        a_start = 1'b1;
        a_cycle(2'b00, 32'h0, 32'h0);
        a_start = 1'b0;
    endtask

    task automatic b_start_matrix();
        b_start = 1'b1;
        b_cycle(4'b0000, 128'h0);
        b_start = 1'b0;
    endtask

    task automatic a_wait_done(input string tag);
        int n = 0;
        while (!a_done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 160'(a_done), 160'(1));
    endtask

    task automatic b_wait_done(input string tag);
        int n = 0;
        while (!b_done && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 160'(b_done), 160'(1));
    endtask

    function automatic logic [31:0] bval(input int r, input int j);
        return 32'hB000_0000 + 32'(r * 256 + j);
    endfunction

    function automatic logic [127:0] brow(input int r);
        logic [127:0] row = '0;
        for (int j = 0; j < 4; j++) row[j*32 +: 32] = bval(r, j);
        return row;
    endfunction

    // Drive cnt rows starting at row `first` with column j skewed j cycles.
    task automatic b_stream(input int first, input int cnt);
        logic [3:0]   v;
        logic [127:0] d;
        for (int c = 0; c < cnt + 3; c++) begin
            v = '0;
            d = '0;
            for (int j = 0; j < 4; j++) begin
                if (c - j >= 0 && c - j < cnt) begin
                    v[j] = 1'b1;
                    d[j*32 +: 32] = bval(first + c - j, j);
                end
            end
            b_cycle(v, d);
        end
    endtask

    // Scoreboard for A: every handshake must match the oldest expected row.
    always @(negedge clk) begin : mon_a
        logic [65:0] e;
        if (a_row_valid && a_row_ready) begin
            $display("[TB] A row out idx=%0d data=%h", a_row_index, a_row_data);
            tests++;
            assert (a_q.size() > 0) else begin
                fails++;
                $error("FAIL a_unexpected_row observed idx=%0d data=%h expected no row", a_row_index, a_row_data);
            end
            if (a_q.size() > 0) begin
                e = a_q.pop_front();
                check("a_row_data",  160'(a_row_data),  160'(e[63:0]));
                check("a_row_index", 160'(a_row_index), 160'(e[65:64]));
            end
        end
    end

    // Scoreboard for B.
    always @(negedge clk) begin : mon_b
        logic [130:0] e;
        if (b_row_valid && b_row_ready) begin
            $display("[TB] B row out idx=%0d data=%h", b_row_index, b_row_data);
            tests++;
            assert (b_q.size() > 0) else begin
                fails++;
                $error("FAIL b_unexpected_row observed idx=%0d data=%h expected no row", b_row_index, b_row_data);
            end
            if (b_q.size() > 0) begin
                e = b_q.pop_front();
                check("b_row_data",  160'(b_row_data),  160'(e[127:0]));
                check("b_row_index", 160'(b_row_index), 160'(e[130:128]));
            end
        end
    end

    initial begin
        reset = 1'b1;
        general_enable = 1'b1;
        a_start = 1'b0; a_row_ready = 1'b1; a_col_valid = '0; a_col_data = '0;
        b_start = 1'b0; b_row_ready = 1'b0; b_col_valid = '0; b_col_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_a_reset("a_reset");

        // First row of a matrix: exact latency and data packing.
        a_start_matrix();
        check("a_busy_collect", 160'(a_busy), 160'(1));
        a_cycle(2'b01, 32'h11, 32'h0);
        a_q.push_back({2'd0, 32'h22, 32'h11});
        a_cycle(2'b10, 32'h0, 32'h22);
        a_col_valid = '0; a_col_data = '0;
        check("a_lat_early", 160'(a_row_valid), 160'(0));
        @(posedge clk); #1;
        check("a_lat_row_valid", 160'(a_row_valid), 160'(1));
        @(posedge clk); #1;

        // Second row closes the matrix: done rises the cycle after the last pop.
        a_cycle(2'b01, 32'h33, 32'h0);
        a_q.push_back({2'd1, 32'h44, 32'h33});
        a_cycle(2'b10, 32'h0, 32'h44);
        a_col_valid = '0;
        for (int n = 0; n < 10 && !a_row_valid; n++) begin
            @(posedge clk); #1;
        end
        check("a_row1_valid", 160'(a_row_valid), 160'(1));
        check("a_done_before_pop", 160'(a_done), 160'(0));
        @(posedge clk); #1;
        check("a_done_after_pop", 160'(a_done), 160'(1));
        check("a_busy_after_pop", 160'(a_busy), 160'(0));
        check("a_empty_after_pop", 160'(a_row_valid), 160'(0));

        // Back-to-back rows.
        a_start_matrix();
        a_q.push_back({2'd0, 32'h5A, 32'h55});
        a_q.push_back({2'd1, 32'h6A, 32'h66});
        a_cycle(2'b01, 32'h55, 32'h0);
        a_cycle(2'b11, 32'h66, 32'h5A);
        a_cycle(2'b10, 32'h0, 32'h6A);
        a_col_valid = '0;
        a_wait_done("a_b2b_done");
        check("a_b2b_sb_empty", 160'(a_q.size()), 160'(0));
        check("a_b2b_no_ovf", 160'(a_overflow), 160'(0));

        // Freeze mid-skew for three cycles: inputs ignored, row delayed but intact.
        a_start_matrix();
        a_cycle(2'b01, 32'h77, 32'h0);
        general_enable = 1'b0;
        repeat (3) a_cycle(2'b11, 32'hDEAD, 32'hBEEF);
        check("a_ge_frozen", 160'(a_row_valid), 160'(0));
        general_enable = 1'b1;
        a_q.push_back({2'd0, 32'h88, 32'h77});
        a_cycle(2'b10, 32'h0, 32'h88);
        a_col_valid = '0;
        check("a_ge_lat_early", 160'(a_row_valid), 160'(0));
        @(posedge clk); #1;
        check("a_ge_lat_row_valid", 160'(a_row_valid), 160'(1));
        @(posedge clk); #1;

        // Buffer the last row in DRAIN, then reset asynchronously.
        a_row_ready = 1'b0;
        a_q.push_back({2'd1, 32'hAA, 32'h99});
        a_cycle(2'b01, 32'h99, 32'h0);
        a_cycle(2'b10, 32'h0, 32'hAA);
        a_col_valid = '0;
        @(posedge clk); #1;
        check("a_drain_busy", 160'(a_busy), 160'(1));
        check("a_drain_valid", 160'(a_row_valid), 160'(1));
        check("a_drain_index", 160'(a_row_index), 160'(1));
        reset = 1'b1;
        #2;
        check_a_reset("a_midreset");
        a_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        a_row_ready = 1'b1;
        a_start_matrix();
        a_q.push_back({2'd0, 32'hC1, 32'hC0});
        a_q.push_back({2'd1, 32'hD1, 32'hD0});
        a_cycle(2'b01, 32'hC0, 32'h0);
        a_cycle(2'b11, 32'hD0, 32'hC1);
        a_cycle(2'b10, 32'h0, 32'hD1);
        a_col_valid = '0;
        a_wait_done("a_post_reset_done");

        // Column 1 valid without column 0.
        a_start_matrix();
        a_q.push_back({2'd0, 32'h99, 32'h0});
        a_cycle(2'b10, 32'h0, 32'h99);
        a_col_valid = '0;
        @(posedge clk); #1;
        check("a_err_misaligned", 160'(a_err), 160'(EXP_ERR));
        a_q.push_back({2'd1, 32'hE1, 32'hE0});
        a_cycle(2'b01, 32'hE0, 32'h0);
        a_cycle(2'b10, 32'h0, 32'hE1);
        a_col_valid = '0;
        a_wait_done("a_err_done");
        check("a_err_sticky", 160'(a_err), 160'(EXP_ERR));
        a_start_matrix();
        check("a_err_cleared", 160'(a_err), 160'(0));
        check("a_restart_busy", 160'(a_busy), 160'(1));

        // B: four rows into a two-deep FIFO with no drain -> two kept, overflow.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        b_row_ready = 1'b0;
        b_start_matrix();
        b_q.push_back({3'd0, brow(0)});
        b_q.push_back({3'd1, brow(1)});
        b_stream(0, 4);
        b_col_valid = '0; b_col_data = '0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("b_overflow_set", 160'(b_overflow), 160'(1));
        check("b_ovf_head_valid", 160'(b_row_valid), 160'(1));
        check("b_ovf_head_index", 160'(b_row_index), 160'(0));
        check("b_ovf_head_data", 160'(b_row_data), 160'(brow(0)));
        @(posedge clk); #1;
        check("b_head_hold_data", 160'(b_row_data), 160'(brow(0)));
        check("b_head_hold_index", 160'(b_row_index), 160'(0));
        b_row_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("b_ovf_sb_empty", 160'(b_q.size()), 160'(0));
        check("b_ovf_drained", 160'(b_row_valid), 160'(0));

        // B: full FIFO, push coincides with a pop -> row kept, no overflow.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        b_row_ready = 1'b0;
        b_start_matrix();
        b_q.push_back({3'd0, brow(0)});
        b_q.push_back({3'd1, brow(1)});
        b_stream(0, 2);
        b_col_valid = '0; b_col_data = '0;
        @(posedge clk); #1;
        b_q.push_back({3'd2, brow(2)});
        b_stream(2, 1);
        b_col_valid = '0; b_col_data = '0;
        b_row_ready = 1'b1;
        @(posedge clk); #1;
        b_row_ready = 1'b0;
        check("b_pushpop_no_ovf", 160'(b_overflow), 160'(0));
        check("b_pushpop_valid", 160'(b_row_valid), 160'(1));
        check("b_pushpop_index", 160'(b_row_index), 160'(1));
        b_row_ready = 1'b1;
        b_q.push_back({3'd3, brow(3)});
        b_stream(3, 1);
        b_col_valid = '0; b_col_data = '0;
        b_wait_done("b_done");
        check("b_final_no_ovf", 160'(b_overflow), 160'(0));
        check("b_final_sb_empty", 160'(b_q.size()), 160'(0));
        check("b_final_busy", 160'(b_busy), 160'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
